// File: rtl/reg_ctx_sequencer_if.sv
// Memory-side request/acknowledge bus between the context sequencer (master)
// and the data memory (slave).
interface reg_ctx_sequencer_if;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/reg_ctx_sequencer.sv
// Context save/restore sequencer: streams a register range between the 64x32
// bank and data memory, owning the bank's third read port and its write port.
module reg_ctx_sequencer #(
    parameter int FIRST_REG   = 1,
    parameter int LAST_REG    = 50,
    parameter int ADDR_STRIDE = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    op_i,
    input  logic [31:0]             base_addr_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    cpu_stall_o,
    input  logic                    cpu_reg_write_i,
    input  logic [5:0]              cpu_reg_1_i,
    input  logic [31:0]             cpu_write_data_i,
    output logic                    rb_reg_write_o,
    output logic [5:0]              rb_reg_1_o,
    output logic [31:0]             rb_write_data_o,
    output logic [5:0]              rb_reg_3_o,
    input  logic [31:0]             rb_data_3_i,
    reg_ctx_sequencer_if.master     mem
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SAVE_REQ = 3'd1;
    localparam logic [2:0] LOAD_REQ = 3'd2;
    localparam logic [2:0] LOAD_WR  = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam logic [5:0]  FIRST_IDX = 6'(FIRST_REG);
    localparam logic [5:0]  LAST_IDX  = 6'(LAST_REG);
    localparam logic [31:0] FIRST_OFS = 32'(FIRST_REG);
    localparam logic [31:0] STRIDE    = 32'(ADDR_STRIDE);

    logic [2:0]  state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] base_q, base_d;
    logic [31:0] rdata_q, rdata_d;

    logic        save_st;
    logic        load_st;
    logic        wr_st;
    logic        busy;
    logic [31:0] offset;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    base_d  = base_addr_i;
                    idx_d   = FIRST_IDX;
                    state_d = op_i ? LOAD_REQ : SAVE_REQ;
                end
            end
            SAVE_REQ: begin
                if (mem.mem_ack) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            LOAD_REQ: begin
                if (mem.mem_ack) begin
                    rdata_d = mem.mem_rdata;
                    state_d = LOAD_WR;
                end
            end
            LOAD_WR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = LOAD_REQ;
                end
            end
            DONE: begin
                idx_d   = FIRST_IDX;
                state_d = IDLE;
            end
            default: begin
                idx_d   = FIRST_IDX;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= FIRST_IDX;
            base_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            rdata_q <= rdata_d;
        end
    end

    assign save_st = (state_q == SAVE_REQ);
    assign load_st = (state_q == LOAD_REQ);
    assign wr_st   = (state_q == LOAD_WR);
    assign busy    = save_st | load_st | wr_st;

    // Outputs decode straight from state so an async reset drops them at once.
    assign offset = (32'(idx_q) - FIRST_OFS) * STRIDE;

    assign mem.mem_req   = save_st | load_st;
    assign mem.mem_write = save_st;
    assign mem.mem_addr  = (save_st | load_st) ? (base_q + offset) : '0;
    assign mem.mem_wdata = save_st ? rb_data_3_i : '0;

    assign busy_o      = busy;
    assign cpu_stall_o = busy;
    assign done_o      = (state_q == DONE);
    assign rb_reg_3_o  = busy ? idx_q : 6'd0;

    // Index 0 is the hardwired-zero register and must never see a write strobe.
    assign rb_reg_write_o  = busy ? (wr_st && (idx_q != 6'd0)) : cpu_reg_write_i;
    assign rb_reg_1_o      = busy ? idx_q : cpu_reg_1_i;
    assign rb_write_data_o = busy ? rdata_q : cpu_write_data_i;

endmodule

// File: tb/tb_reg_ctx_sequencer.sv
// Scoreboard bench for reg_ctx_sequencer: bank and memory models around the
// default-range instance plus a single-register (index 0) instance.
module tb_reg_ctx_sequencer;

    localparam int N = 50;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
    } xferT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, op;
    logic [31:0] baseAddr;
    logic        busy, done, cpuStall;
    logic        cpuRegWrite;
    logic [5:0]  cpuReg1;
    logic [31:0] cpuWriteData;
    logic        rbRegWrite;
    logic [5:0]  rbReg1;
    logic [31:0] rbWriteData;
    logic [5:0]  rbReg3;
    logic [31:0] rbData3;
    logic        ackEn;

    logic        start1, op1;
    logic [31:0] baseAddr1;
    logic        busy1, done1, cpuStall1;
    logic        rbRegWrite1;
    logic [5:0]  rbReg1_1, rbReg3_1;
    logic [31:0] rbWriteData1;

    logic [31:0] bank    [64];
    logic [31:0] refBank [64];
    xferT        expQ[$];

    int checkCount = 0;
    int errorCount = 0;
    int busyCycles = 0;
    int doneCount  = 0;
    int xfer1      = 0;
    int writes1    = 0;
    logic [31:0] lastAddr1  = '0;
    logic        lastWrite1 = 1'b1;

    always #5 clk = ~clk;

    reg_ctx_sequencer_if memBus ();
    reg_ctx_sequencer_if memBus1 ();

    assign memBus.mem_ack    = ackEn;
    assign memBus.mem_rdata  = memBus.mem_addr ^ 32'h0000A5A5;
    assign memBus1.mem_ack   = 1'b1;
    assign memBus1.mem_rdata = memBus1.mem_addr ^ 32'h0000A5A5;

    reg_ctx_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start),
        .op_i             (op),
        .base_addr_i      (baseAddr),
        .busy_o           (busy),
        .done_o           (done),
        .cpu_stall_o      (cpuStall),
        .cpu_reg_write_i  (cpuRegWrite),
        .cpu_reg_1_i      (cpuReg1),
        .cpu_write_data_i (cpuWriteData),
        .rb_reg_write_o   (rbRegWrite),
        .rb_reg_1_o       (rbReg1),
        .rb_write_data_o  (rbWriteData),
        .rb_reg_3_o       (rbReg3),
        .rb_data_3_i      (rbData3),
        .mem              (memBus.master)
    );

    reg_ctx_sequencer #(.FIRST_REG(0), .LAST_REG(0), .ADDR_STRIDE(4)) dutZero (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start1),
        .op_i             (op1),
        .base_addr_i      (baseAddr1),
        .busy_o           (busy1),
        .done_o           (done1),
        .cpu_stall_o      (cpuStall1),
        .cpu_reg_write_i  (1'b0),
        .cpu_reg_1_i      (6'd0),
        .cpu_write_data_i (32'd0),
        .rb_reg_write_o   (rbRegWrite1),
        .rb_reg_1_o       (rbReg1_1),
        .rb_write_data_o  (rbWriteData1),
        .rb_reg_3_o       (rbReg3_1),
        .rb_data_3_i      (32'd0),
        .mem              (memBus1.master)
    );

    // Register bank model; index 0 reads as zero and ignores writes.
    always @(posedge clk) begin
        if (rbRegWrite && rbReg1 != 6'd0) bank[rbReg1] <= rbWriteData;
    end
    assign rbData3 = (rbReg3 == 6'd0) ? 32'd0 : bank[rbReg3];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busyCycles++;
            if (done) doneCount++;
            if (memBus.mem_req) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedReq", 32'd1, 32'd0);
                end else begin
                    checkOutput("memAddr", memBus.mem_addr, expQ[0].addr);
                    checkOutput("memWrite", 32'(memBus.mem_write), 32'(expQ[0].write));
                    if (expQ[0].write) checkOutput("memWdata", memBus.mem_wdata, expQ[0].data);
                    if (memBus.mem_ack) void'(expQ.pop_front());
                end
            end
            if (busy && rbRegWrite && rbReg1 == 6'd0) checkOutput("reg0Write", 32'd1, 32'd0);
            if (memBus1.mem_req && memBus1.mem_ack) begin
                xfer1++;
                lastAddr1  = memBus1.mem_addr;
                lastWrite1 = memBus1.mem_write;
            end
            if (rbRegWrite1) writes1++;
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic compareBank(input string tag);
        for (int k = 1; k < 64; k++) checkOutput($sformatf("%s[%0d]", tag, k), bank[k], refBank[k]);
    endtask

    // mode 0 plain, 1 ack stall on 2nd transfer, 2 CPU write + extra Start, 3 reset at reg 10
    task automatic applyStimulus(input logic opIn, input logic [31:0] base, input int mode,
                                 input int expCycles, input int expBusy);
        int cycles;
        bit seen;
        bit aborted;
        for (int k = 1; k <= N; k++) begin
            xferT t;
            t.addr  = base + 32'((k - 1) * 4);
            t.write = !opIn;
            t.data  = refBank[k];
            expQ.push_back(t);
        end
        busyCycles = 0;
        doneCount  = 0;
        start      = 1'b1;
        op         = opIn;
        baseAddr   = base;
        cycles     = 0;
        seen       = 1'b0;
        aborted    = 1'b0;
        while (!seen && cycles < 300) begin
            stepCycle();
            start       = 1'b0;
            cpuRegWrite = 1'b0;
            cycles++;
            if (mode == 1) ackEn = !(cycles >= 2 && cycles <= 4);
            if (mode == 2 && cycles == 10) begin
                checkOutput("cpuStall", 32'(cpuStall), 32'd1);
                cpuRegWrite  = 1'b1;
                cpuReg1      = 6'd5;
                cpuWriteData = 32'hDEAD;
                start        = 1'b1;
            end
            if (mode == 3 && cycles == 19) begin
                checkOutput("abortIdx", 32'(rbReg3), 32'd10);
                rst_n = 1'b0;
                #1;
                checkOutput("abortReq", 32'(memBus.mem_req), 32'd0);
                checkOutput("abortBusy", 32'(busy), 32'd0);
                checkOutput("abortRbWrite", 32'(rbRegWrite), 32'd0);
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        ackEn = 1'b1;
        if (!aborted) begin
            checkOutput("doneLatency", 32'(cycles), 32'(expCycles));
            checkOutput("busyCycles", 32'(busyCycles), 32'(expBusy));
            checkOutput("sbEmpty", 32'(expQ.size()), 32'd0);
            stepCycle();
        end
    endtask

    initial begin
        int cycles;
        rst_n        = 1'b0;
        start        = 1'b0;
        op           = 1'b0;
        baseAddr     = '0;
        cpuRegWrite  = 1'b0;
        cpuReg1      = '0;
        cpuWriteData = '0;
        ackEn        = 1'b1;
        start1       = 1'b0;
        op1          = 1'b0;
        baseAddr1    = '0;
        refBank[0]   = '0;
        #1;
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstReq", 32'(memBus.mem_req), 32'd0);
        checkOutput("rstWrite", 32'(memBus.mem_write), 32'd0);
        checkOutput("rstAddr", memBus.mem_addr, 32'd0);
        checkOutput("rstWdata", memBus.mem_wdata, 32'd0);
        checkOutput("rstStall", 32'(cpuStall), 32'd0);
        checkOutput("rstReg3", 32'(rbReg3), 32'd0);
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
        stepCycle();

        // Preload through the CPU pass-through path while idle.
        for (int k = 1; k < 64; k++) begin
            cpuRegWrite  = 1'b1;
            cpuReg1      = 6'(k);
            cpuWriteData = (k == 1) ? 32'h11 : (k == 50) ? 32'h3232 : (32'hC0DE0000 | 32'(k));
            refBank[k]   = cpuWriteData;
            stepCycle();
        end
        cpuRegWrite = 1'b0;
        compareBank("preload");

        $display("[TB] save base 0x1000");
        applyStimulus(1'b0, 32'h1000, 0, N + 1, N);

        $display("[TB] restore base 0x2000");
        applyStimulus(1'b1, 32'h2000, 0, 2 * N + 1, 2 * N);
        for (int k = 1; k <= N; k++) refBank[k] = (32'h2000 + 32'((k - 1) * 4)) ^ 32'h0000A5A5;
        compareBank("restore");

        $display("[TB] save with ack stall");
        applyStimulus(1'b0, 32'h1000, 1, N + 4, N + 3);

        $display("[TB] save with CPU write and repeated start");
        applyStimulus(1'b0, 32'h6000, 2, N + 1, N);
        repeat (4) stepCycle();
        checkOutput("singleDone", 32'(doneCount), 32'd1);
        checkOutput("reg5Kept", bank[5], refBank[5]);

        $display("[TB] restore aborted by reset");
        applyStimulus(1'b1, 32'h3000, 3, 0, 0);
        expQ.delete();
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
        checkOutput("postAbortBusy", 32'(busy), 32'd0);
        for (int k = 1; k <= 9; k++) refBank[k] = (32'h3000 + 32'((k - 1) * 4)) ^ 32'h0000A5A5;
        compareBank("abort");
        applyStimulus(1'b0, 32'h4000, 0, N + 1, N);

        $display("[TB] single register range at index 0");
        xfer1     = 0;
        writes1   = 0;
        start1    = 1'b1;
        op1       = 1'b1;
        baseAddr1 = 32'h5000;
        cycles    = 0;
        while (cycles < 20) begin
            stepCycle();
            start1 = 1'b0;
            cycles++;
            @(negedge clk);
            if (done1) break;
        end
        checkOutput("zeroLatency", 32'(cycles), 32'd3);
        stepCycle();
        checkOutput("zeroXfers", 32'(xfer1), 32'd1);
        checkOutput("zeroAddr", lastAddr1, 32'h5000);
        checkOutput("zeroIsRead", 32'(lastWrite1), 32'd0);
        checkOutput("zeroWrites", 32'(writes1), 32'd0);
        checkOutput("zeroIdle", 32'(busy1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
